write_pacer: RTL and testbench

WRITE_PACER -- requirements
Module: write_pacer

---
 rtl/galetron_write_pkg.sv | 14 +
 rtl/slow_edge_detect.sv | 20 ++
 rtl/write_pacer.sv | 133 +++++++++++++
 tb/tb_write_pacer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/galetron_write_pkg.sv
// Shared types and default widths for the write pacing path.
package galetron_write_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 10;
  localparam int unsigned DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } pacer_state_e;

endpackage

// File: rtl/slow_edge_detect.sv
// Registers the divided write clock once and flags its rising/falling edges.
module slow_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic slow,
  output logic rise_c,
  output logic fall_c
);

  logic slow_q;

  always_ff @(posedge clk) begin
    if (rst) slow_q <= 1'b0;
    else     slow_q <= slow;
  end

  assign rise_c = slow & ~slow_q;
  assign fall_c = ~slow & slow_q;

endmodule

// File: rtl/write_pacer.sv
// Buffers processor writes and replays them one per SLOW_CLK period.
// Optional sticky OVERFLOW output with WRITE_PACER_OVERFLOW_FLAG_EN.
module write_pacer
  import galetron_write_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          IN_50Mhz,
  input  logic                          RESET,
  input  logic                          SLOW_CLK,
  input  logic                          IN_WRITE_REQ,
  input  logic [ADDR_WIDTH-1:0]         IN_ADDR,
  input  logic [DATA_WIDTH-1:0]         IN_DATA,
  output logic                          IN_READY,
  output logic                          OUT_WE,
  output logic [ADDR_WIDTH-1:0]         OUT_ADDR,
  output logic [DATA_WIDTH-1:0]         OUT_DATA,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          BUSY
`ifdef WRITE_PACER_OVERFLOW_FLAG_EN
  ,
  output logic                          OVERFLOW
`endif
);

  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LVL_W-1:0]   count, count_nxt;
  pacer_state_e       state, state_nxt;
  logic               rise_c, fall_c;
  logic               push_c, pop_c, we_nxt;

  slow_edge_detect u_edge (
    .clk    (IN_50Mhz),
    .rst    (RESET),
    .slow   (SLOW_CLK),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // IN_READY is itself a register of (count < depth), so a pop never frees a slot the same cycle
  assign push_c = IN_WRITE_REQ & IN_READY;
  assign LEVEL  = count;

  always_ff @(posedge IN_50Mhz) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state, pop request and next write enable
  always_comb begin
    state_nxt = state;
    pop_c     = 1'b0;
    we_nxt    = OUT_WE;
    case (state)
      IDLE: begin
        if (rise_c && (count != LVL_W'(0))) begin
          pop_c     = 1'b1;
          we_nxt    = 1'b1;
          state_nxt = ASSERT;
        end
      end
      ASSERT: begin
        if (fall_c) begin
          we_nxt    = 1'b0;
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (rise_c) begin
          if (count != LVL_W'(0)) begin
            pop_c     = 1'b1;
            we_nxt    = 1'b1;
            state_nxt = ASSERT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        we_nxt    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (push_c && !pop_c)      count_nxt = count + LVL_W'(1);
    else if (!push_c && pop_c) count_nxt = count - LVL_W'(1);
  end

  always_ff @(posedge IN_50Mhz) begin
    if (!RESET && push_c) mem[wr_ptr] <= {IN_ADDR, IN_DATA};
  end

  always_ff @(posedge IN_50Mhz) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      IN_READY <= 1'b1;
      BUSY     <= 1'b0;
      OUT_WE   <= 1'b0;
      OUT_ADDR <= '0;
      OUT_DATA <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c) begin
        rd_ptr               <= rd_ptr + PTR_W'(1);
        {OUT_ADDR, OUT_DATA} <= mem[rd_ptr];
      end
      count    <= count_nxt;
      IN_READY <= (count_nxt < LVL_W'(FIFO_DEPTH));
      BUSY     <= (count_nxt != LVL_W'(0)) || (state_nxt != IDLE);
      OUT_WE   <= we_nxt;
    end
  end

`ifdef WRITE_PACER_OVERFLOW_FLAG_EN
  always_ff @(posedge IN_50Mhz) begin
    if (RESET)                          OVERFLOW <= 1'b0;
    else if (IN_WRITE_REQ && !IN_READY) OVERFLOW <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_write_pacer.sv
// Directed bench for write_pacer with a behavioural 128-cycle write clock divider.
module tb_write_pacer;
  import galetron_write_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic          clk = 1'b0;
  logic          rst, slow, req, ready, we, busy, div_rst;
  logic [AW-1:0] addr, oaddr;
  logic [DW-1:0] data, odata;
  logic [3:0]    level;
  logic [6:0]    div_cnt;
`ifdef WRITE_PACER_OVERFLOW_FLAG_EN
  logic          overflow;
`endif

  int errors = 0;
  int checks = 0;
  int n;

  write_pacer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(8)) dut (
    .IN_50Mhz     (clk),
    .RESET        (rst),
    .SLOW_CLK     (slow),
    .IN_WRITE_REQ (req),
    .IN_ADDR      (addr),
    .IN_DATA      (data),
    .IN_READY     (ready),
    .OUT_WE       (we),
    .OUT_ADDR     (oaddr),
    .OUT_DATA     (odata),
    .LEVEL        (level),
    .BUSY         (busy)
`ifdef WRITE_PACER_OVERFLOW_FLAG_EN
    ,
    .OVERFLOW     (overflow)
`endif
  );

  always #10 clk = ~clk;

  // Divided write clock: 64 cycles low then 64 high; held low while div_rst
  always @(posedge clk) begin
    if (div_rst) begin
      div_cnt <= 7'd0;
      slow    <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 7'd1;
      if (div_cnt == 7'd63)       slow <= 1'b1;
      else if (div_cnt == 7'd127) slow <= 1'b0;
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a;
    data = d;
    req  = 1'b1;
    step();
    req  = 1'b0;
  endtask

  // Returns at the first negedge where SLOW_CLK is newly high
  task automatic wait_slow_rise(input string tag);
    logic prev;
    bit   seen;
    seen = 1'b0;
    prev = slow;
    for (int i = 0; i < 300; i++) begin
      step();
      if (slow && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = slow;
    end
    check(tag, 64'(seen), 64'd1);
  endtask

  task automatic we_rise_gap(output int cnt);
    logic prev;
    prev = we;
    cnt  = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      cnt++;
      if (we && !prev) break;
      prev = we;
    end
  endtask

  task automatic we_high_len(output int cnt);
    cnt = 1;
    for (int i = 0; i < 400; i++) begin
      step();
      if (!we) break;
      cnt++;
    end
  endtask

  initial begin
    rst = 1'b1; div_rst = 1'b1; req = 1'b0; addr = '0; data = '0;
    step(); step();
    check("reset_we",    64'(we),    64'd0);
    check("reset_level", 64'(level), 64'd0);
    check("reset_busy",  64'(busy),  64'd0);
    check("reset_ready", 64'(ready), 64'd1);
    check("reset_state", 64'(dut.state), 64'(IDLE));
    check("reset_oaddr", 64'(oaddr), 64'd0);
    check("reset_odata", 64'(odata), 64'd0);
    rst = 1'b0; div_rst = 1'b0;
    step();

    // Single write
    push(10'h005, 32'hDEADBEEF);
    check("single_level", 64'(level), 64'd1);
    check("single_busy",  64'(busy),  64'd1);
    check("single_we_early", 64'(we), 64'd0);
    wait_slow_rise("single_rise");
    check("single_we_at_rise", 64'(we), 64'd0);
    step();
    check("single_we",    64'(we),    64'd1);
    check("single_addr",  64'(oaddr), 64'h005);
    check("single_data",  64'(odata), 64'hDEADBEEF);
    check("single_level0", 64'(level), 64'd0);
    we_high_len(n);
    check("single_we_len", 64'(n), 64'd64);
    check("single_busy_hold", 64'(busy), 64'd1);
    wait_slow_rise("single_rise2");
    check("single_busy_at_rise", 64'(busy), 64'd1);
    step();
    check("single_busy_drop", 64'(busy), 64'd0);
    check("single_idle", 64'(dut.state), 64'(IDLE));

    // Burst of three
    push(10'h010, 32'h111);
    push(10'h011, 32'h222);
    push(10'h012, 32'h333);
    check("burst_level3", 64'(level), 64'd3);
    wait_slow_rise("burst_rise");
    step();
    check("burst_we0",   64'(we),    64'd1);
    check("burst_addr0", 64'(oaddr), 64'h010);
    check("burst_data0", 64'(odata), 64'h111);
    check("burst_level2", 64'(level), 64'd2);
    we_rise_gap(n);
    check("burst_gap1",  64'(n),     64'd128);
    check("burst_addr1", 64'(oaddr), 64'h011);
    check("burst_data1", 64'(odata), 64'h222);
    check("burst_level1", 64'(level), 64'd1);
    we_rise_gap(n);
    check("burst_gap2",  64'(n),     64'd128);
    check("burst_addr2", 64'(oaddr), 64'h012);
    check("burst_data2", 64'(odata), 64'h333);
    check("burst_level0", 64'(level), 64'd0);

    // Overflow with the write clock stopped
    div_rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(AW'(10'h020 + i), DW'(32'h1000 + i));
      if (i == 6) check("ovf_ready_at7", 64'(ready), 64'd1);
    end
    check("ovf_level8", 64'(level), 64'd8);
    check("ovf_ready0", 64'(ready), 64'd0);
    push(10'h1FF, 32'hBAD);
    step();
    check("ovf_level_after9", 64'(level), 64'd8);
    check("ovf_no_write", 64'(we), 64'd0);
`ifdef WRITE_PACER_OVERFLOW_FLAG_EN
    check("ovf_flag", 64'(overflow), 64'd1);
`endif

    // Drain with a simultaneous push/pop at LEVEL=4 across pointer wrap
    div_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_slow_rise("wrap_rise");
      step();
      check("wrap_data",  64'(odata), 64'(32'h1000 + k));
      check("wrap_level", 64'(level), 64'(7 - k));
    end
    wait_slow_rise("wrap_rise_pp");
    addr = 10'h028; data = 32'h1008; req = 1'b1;
    step();
    req = 1'b0;
    check("pp_level", 64'(level), 64'd4);
    check("pp_data",  64'(odata), 64'h1004);
    for (int k = 5; k < 9; k++) begin
      wait_slow_rise("wrap_rise_tail");
      step();
      check("wrap_tail_addr",  64'(oaddr), 64'(10'h020 + k));
      check("wrap_tail_data",  64'(odata), 64'(32'h1000 + k));
      check("wrap_tail_level", 64'(level), 64'(8 - k));
    end

    // Reset during ASSERT discards the buffered entries
    push(10'h030, 32'hCAFE);
    push(10'h031, 32'hF00D);
    check("rst_pre_level", 64'(level), 64'd2);
    check("rst_pre_we",    64'(we),    64'd1);
    repeat (8) step();
    rst = 1'b1;
    step();
    check("rst_we",    64'(we),    64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_state", 64'(dut.state), 64'(IDLE));
    check("rst_busy",  64'(busy),  64'd0);
    rst = 1'b0;
    wait_slow_rise("rst_rise");
    step();
    check("rst_no_write", 64'(we), 64'd0);
    check("rst_level_after", 64'(level), 64'd0);

    // Push into empty FIFO on the same cycle as a rise
    wait_slow_rise("same_rise");
    push(10'h03A, 32'hA5A5);
    check("same_level", 64'(level), 64'd1);
    check("same_we0",   64'(we),    64'd0);
    we_rise_gap(n);
    check("same_gap",  64'(n),     64'd128);
    check("same_addr", 64'(oaddr), 64'h03A);
    check("same_data", 64'(odata), 64'hA5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
